stream_crop_window: RTL and testbench

- Streaming crop stage that sits directly upstream of the CNN core.
- Consumes a full IN_ROWS x IN_COLS raster-order pixel stream, one pixel per beat.
- Forwards only the OUT_ROWS x OUT_COLS window whose top-left corner is (crop_y1, crop_x1), in raster order, to the CNN input stream.
- Frame control uses the ap_start / ap_done / ap_idle / ap_ready block-level protocol.

---
 rtl/stream_crop_pkg.sv | 21 ++
 rtl/stream_crop_out_reg.sv | 49 ++++
 rtl/stream_crop_window.sv | 160 ++++++++++++++++
 tb/tb_stream_crop_window.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_crop_pkg.sv
// Shared types and helpers for the stream_crop_window crop stage.
// Holds the frame FSM encoding, counter-width helper and origin saturation.
package stream_crop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } crop_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a requested window origin so the whole window stays inside the frame.
    function automatic int sat_origin(input int req, input int max_origin);
        return (req > max_origin) ? max_origin : req;
    endfunction

endpackage

// File: rtl/stream_crop_out_reg.sv
// Single-entry AXI-stream output register: load, drain or hold one beat.
// With HAS_LAST the payload carries one extra TLAST bit above the pixel word.
module stream_crop_out_reg #(
    parameter int  FP_TOTAL = 16,
    parameter bit  HAS_LAST = 1'b0,
    localparam int PW       = FP_TOTAL + (HAS_LAST ? 1 : 0)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] load_data,
    input  logic          ready,
    output logic          valid,
    output logic [PW-1:0] data
);

    logic          valid_q, valid_d;
    logic [PW-1:0] data_q,  data_d;

    // A load only arrives when the slot is empty or draining, so it never clobbers a held beat.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (ready) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/stream_crop_window.sv
// Crops an OUT_ROWS x OUT_COLS window out of a raster pixel stream feeding the CNN core.
// Define STREAM_CROP_TLAST_EN to add crop_out_TLAST on the final window beat.
module stream_crop_window
    import stream_crop_pkg::*;
#(
    parameter int FP_TOTAL = 16,
    parameter int IN_ROWS  = 100,
    parameter int IN_COLS  = 160,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    input  logic [cnt_w(IN_ROWS)-1:0]  crop_y1,
    input  logic [cnt_w(IN_COLS)-1:0]  crop_x1,
    input  logic [FP_TOTAL-1:0]        img_in_TDATA,
    input  logic                       img_in_TVALID,
    output logic                       img_in_TREADY,
    output logic [FP_TOTAL-1:0]        crop_out_TDATA,
    output logic                       crop_out_TVALID,
`ifdef STREAM_CROP_TLAST_EN
    output logic                       crop_out_TLAST,
`endif
    input  logic                       crop_out_TREADY
);

    localparam int RW = cnt_w(IN_ROWS);
    localparam int CW = cnt_w(IN_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
    localparam logic [RW:0]   WIN_H    = (RW + 1)'(OUT_ROWS);
    localparam logic [CW:0]   WIN_W    = (CW + 1)'(OUT_COLS);
`ifdef STREAM_CROP_TLAST_EN
    localparam bit HAS_LAST = 1'b1;
`else
    localparam bit HAS_LAST = 1'b0;
`endif
    localparam int PW = FP_TOTAL + (HAS_LAST ? 1 : 0);

    crop_state_e   state_q, state_d;
    logic [RW-1:0] row_q, row_d, y0_q, y0_d;
    logic [CW-1:0] col_q, col_d, x0_q, x0_d;

    logic          in_xfer_s, in_win_s, win_last_s, out_valid_s;
    logic [PW-1:0] load_data_s, out_payload_s;

    assign in_xfer_s     = img_in_TVALID && img_in_TREADY;
    assign img_in_TREADY = (state_q == ST_RUN) && (!out_valid_s || crop_out_TREADY);

    // Window membership is evaluated one bit wider so origin + size cannot overflow.
    always_comb begin
        in_win_s   = 1'b0;
        win_last_s = 1'b0;
        if (({1'b0, row_q} >= {1'b0, y0_q}) && ({1'b0, row_q} < ({1'b0, y0_q} + WIN_H)) &&
            ({1'b0, col_q} >= {1'b0, x0_q}) && ({1'b0, col_q} < ({1'b0, x0_q} + WIN_W))) begin
            in_win_s   = 1'b1;
            win_last_s = ({1'b0, row_q} == ({1'b0, y0_q} + WIN_H - (RW + 1)'(1))) &&
                         ({1'b0, col_q} == ({1'b0, x0_q} + WIN_W - (CW + 1)'(1)));
        end else begin
            in_win_s   = 1'b0;
            win_last_s = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        y0_d    = y0_q;
        x0_d    = x0_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    state_d = ST_RUN;
                    y0_d    = RW'(sat_origin(int'(crop_y1), IN_ROWS - OUT_ROWS));
                    x0_d    = CW'(sat_origin(int'(crop_x1), IN_COLS - OUT_COLS));
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_xfer_s) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!out_valid_s || crop_out_TREADY) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            y0_q    <= '0;
            x0_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            y0_q    <= y0_d;
            x0_q    <= x0_d;
        end
    end

    assign ap_idle  = (state_q == ST_IDLE);
    assign ap_done  = (state_q == ST_DONE);
    assign ap_ready = (state_q == ST_DONE);

`ifdef STREAM_CROP_TLAST_EN
    assign load_data_s    = {win_last_s, img_in_TDATA};
    assign crop_out_TDATA = out_payload_s[FP_TOTAL-1:0];
    assign crop_out_TLAST = out_payload_s[FP_TOTAL];
`else
    assign load_data_s    = {img_in_TDATA[FP_TOTAL-1:1], img_in_TDATA[0] | (win_last_s & 1'b0)};
    assign crop_out_TDATA = out_payload_s;
`endif

    stream_crop_out_reg #(
        .FP_TOTAL (FP_TOTAL),
        .HAS_LAST (HAS_LAST)
    ) u_out_reg (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .load      (in_xfer_s && in_win_s),
        .load_data (load_data_s),
        .ready     (crop_out_TREADY),
        .valid     (out_valid_s),
        .data      (out_payload_s)
    );

    assign crop_out_TVALID = out_valid_s;

endmodule

// File: tb/tb_stream_crop_window.sv
// Self-checking bench for stream_crop_window against a window-enumeration reference model.
// Build with STREAM_CROP_TLAST_EN defined to also check crop_out_TLAST.
module tb_stream_crop_window;

    localparam int FP   = 16;
    localparam int IR   = 100;
    localparam int IC   = 160;
    localparam int OR   = 48;
    localparam int OC   = 48;
    localparam int NPIX = IR * IC;
    localparam int NWIN = OR * OC;

    logic          ap_clk = 1'b0;
    logic          ap_rst, ap_start;
    logic          ap_done, ap_idle, ap_ready;
    logic [6:0]    crop_y1;
    logic [7:0]    crop_x1;
    logic [FP-1:0] img_in_TDATA;
    logic          img_in_TVALID, img_in_TREADY;
    logic [FP-1:0] crop_out_TDATA;
    logic          crop_out_TVALID, crop_out_TREADY;
`ifdef STREAM_CROP_TLAST_EN
    logic          crop_out_TLAST;
`endif

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    int exp_q[$];
    int got_q[$];
    int ref1_q[$];

    stream_crop_window dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .crop_y1         (crop_y1),
        .crop_x1         (crop_x1),
        .img_in_TDATA    (img_in_TDATA),
        .img_in_TVALID   (img_in_TVALID),
        .img_in_TREADY   (img_in_TREADY),
        .crop_out_TDATA  (crop_out_TDATA),
        .crop_out_TVALID (crop_out_TVALID),
`ifdef STREAM_CROP_TLAST_EN
        .crop_out_TLAST  (crop_out_TLAST),
`endif
        .crop_out_TREADY (crop_out_TREADY)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: enumerate the saturated window in raster order; input pixel value is row*IC+col.
    task automatic build_exp(input int y1, input int x1);
        int y0, x0;
        y0 = (y1 > IR - OR) ? IR - OR : y1;
        x0 = (x1 > IC - OC) ? IC - OC : x1;
        exp_q.delete();
        for (int r = y0; r < y0 + OR; r++)
            for (int c = x0; c < x0 + OC; c++)
                exp_q.push_back(r * IC + c);
    endtask

    task automatic same_as_ref1(input string tag);
        int diff = 0;
        if (got_q.size() != ref1_q.size()) diff = NWIN;
        else foreach (got_q[i]) if (got_q[i] != ref1_q[i]) diff++;
        chk(tag, diff, 0);
    endtask

    // mode 0: always ready, 1: 200-cycle output stall, 2: random valid/ready
    task automatic run_frame(input string tag, input int y1, input int x1, input int mode, input int reset_at);
        int idx = 0;
        int beats = 0;
        int cyc = 0;
        bit done_seen = 1'b0;
        bit hold = 1'b0;
        logic [FP-1:0] held_data = '0;
`ifdef STREAM_CROP_TLAST_EN
        logic held_last = 1'b0;
`endif
        build_exp(y1, x1);
        got_q.delete();
        @(negedge ap_clk);
        crop_y1 = 7'(y1);
        crop_x1 = 8'(x1);
        ap_start = 1'b1;
        img_in_TVALID = 1'b0;
        crop_out_TREADY = 1'b1;
        #1 chk({tag, "_idle_at_start"}, ap_idle, 1);
        while (!done_seen && cyc < 60000) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            crop_y1 = 7'($urandom);
            crop_x1 = 8'($urandom);
            if (mode == 2) begin
                img_in_TVALID   = (idx < NPIX) && ($urandom_range(0, 3) != 0);
                crop_out_TREADY = 1'($urandom_range(0, 1));
            end else if (mode == 1) begin
                img_in_TVALID   = (idx < NPIX);
                crop_out_TREADY = !(cyc >= 3000 && cyc < 3200);
            end else begin
                img_in_TVALID   = (idx < NPIX);
                crop_out_TREADY = 1'b1;
            end
            img_in_TDATA = img_in_TVALID ? 16'(idx) : 16'($urandom);
            #1;
            if (hold) begin
                chk({tag, "_hold_valid"}, crop_out_TVALID, 1);
                chk({tag, "_hold_data"}, crop_out_TDATA, held_data);
`ifdef STREAM_CROP_TLAST_EN
                chk({tag, "_hold_last"}, crop_out_TLAST, held_last);
`endif
            end
            if (crop_out_TVALID && !crop_out_TREADY)
                chk({tag, "_stall_in_ready"}, img_in_TREADY, 0);
            hold = crop_out_TVALID && !crop_out_TREADY;
            held_data = crop_out_TDATA;
`ifdef STREAM_CROP_TLAST_EN
            held_last = crop_out_TLAST;
`endif
            if (crop_out_TVALID && crop_out_TREADY) begin
                if (beats < exp_q.size()) chk({tag, "_beat_data"}, crop_out_TDATA, exp_q[beats]);
                else chk({tag, "_extra_beat"}, beats, exp_q.size());
`ifdef STREAM_CROP_TLAST_EN
                chk({tag, "_tlast"}, crop_out_TLAST, (beats == NWIN - 1));
`endif
                got_q.push_back(int'(crop_out_TDATA));
                beats++;
            end
            if (ap_done) begin
                done_pulses++;
                done_seen = 1'b1;
                chk({tag, "_beats_at_done"}, beats, NWIN);
                chk({tag, "_ready_with_done"}, ap_ready, 1);
            end
            if (img_in_TVALID && img_in_TREADY) idx++;
            if (reset_at > 0 && idx == reset_at) begin
                ap_rst = 1'b1;
                #1;
                chk({tag, "_rst_tvalid"}, crop_out_TVALID, 0);
                chk({tag, "_rst_tdata"}, crop_out_TDATA, 0);
                chk({tag, "_rst_idle"}, ap_idle, 1);
                chk({tag, "_rst_in_ready"}, img_in_TREADY, 0);
                repeat (3) begin
                    @(negedge ap_clk);
                    #1;
                    chk({tag, "_in_rst_tvalid"}, crop_out_TVALID, 0);
                    chk({tag, "_in_rst_done"}, ap_done, 0);
                end
                @(negedge ap_clk);
                ap_rst = 1'b0;
                img_in_TVALID = 1'b0;
                crop_out_TREADY = 1'b1;
                #1 chk({tag, "_idle_after_rst"}, ap_idle, 1);
                return;
            end
            cyc++;
        end
        chk({tag, "_done_seen"}, done_seen, 1);
        chk({tag, "_beat_count"}, beats, NWIN);
    endtask

    initial begin
        ap_rst = 1'b1;
        ap_start = 1'b0;
        crop_y1 = '0;
        crop_x1 = '0;
        img_in_TDATA = '0;
        img_in_TVALID = 1'b0;
        crop_out_TREADY = 1'b1;
        repeat (2) @(negedge ap_clk);
        #1;
        chk("reset_idle", ap_idle, 1);
        chk("reset_done", ap_done, 0);
        chk("reset_ready", ap_ready, 0);
        chk("reset_in_ready", img_in_TREADY, 0);
        chk("reset_tvalid", crop_out_TVALID, 0);
        chk("reset_tdata", crop_out_TDATA, 0);
`ifdef STREAM_CROP_TLAST_EN
        chk("reset_tlast", crop_out_TLAST, 0);
`endif
        @(negedge ap_clk);
        ap_rst = 1'b0;

        run_frame("s1", 10, 10, 0, 0);
        if (got_q.size() >= NWIN) begin
            chk("s1_first", got_q[0], 1610);
            chk("s1_beat48", got_q[48], 1770);
            chk("s1_last", got_q[NWIN-1], 9177);
        end
        ref1_q = got_q;

        run_frame("s2", 10, 10, 1, 0);
        same_as_ref1("s2_vs_s1");
        @(negedge ap_clk);
        #1;
        chk("done_one_cycle", ap_done, 0);
        chk("idle_after_done", ap_idle, 1);

        run_frame("s3", 0, 0, 2, 0);
        if (got_q.size() >= NWIN) begin
            chk("s3_first", got_q[0], 0);
            chk("s3_last", got_q[NWIN-1], 47 * IC + 47);
        end

        run_frame("s4", 90, 150, 0, 0);
        if (got_q.size() >= NWIN) begin
            chk("s4_first", got_q[0], 8432);
            chk("s4_last", got_q[NWIN-1], 15999);
        end

        run_frame("s5", 10, 10, 0, 5000);
        run_frame("s6", 10, 10, 0, 0);
        same_as_ref1("s6_vs_s1");

        chk("done_pulse_total", done_pulses, 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
